// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin arbiter that shares one FIFO write port
// between N_REQ valid/ready producers. A grant lasts for up to MAX_BURST
// accepted beats and never writes while the FIFO is full.
//
// Handshake: a beat moves from requester g to the FIFO in a cycle when
// req_valid[g] && req_ready[g] are both high at the rising clock edge;
// req_ready[g] is high only while g holds the grant and the FIFO is not full,
// and fifo_w_en is exactly that transfer condition.
module fifo_wr_arbiter #(
  parameter int N_REQ     = 4,
  parameter int D_WIDTH   = 8,
  parameter int MAX_BURST = 4
) (
  input  logic                             clk,
  input  logic                             n_rst,
  input  logic [N_REQ-1:0]                 req_valid,
  input  logic [N_REQ*D_WIDTH-1:0]         req_data,
  output logic [N_REQ-1:0]                 req_ready,
  input  logic                             fifo_full,
  output logic                             fifo_w_en,
  output logic [D_WIDTH-1:0]               fifo_w_data,
  output logic                             grant_valid,
  output logic [$clog2(N_REQ)-1:0]         grant_id,
  output logic                             dbg_state_o,
  output logic [$clog2(MAX_BURST+1)-1:0]   dbg_beat_cnt_o
);

  localparam int GID_W = $clog2(N_REQ);
  localparam int BC_W  = $clog2(MAX_BURST + 1);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t             state_q;
  logic [BC_W-1:0]    beat_cnt_q;
  logic [GID_W-1:0]   grant_id_q;
  logic [GID_W-1:0]   last_grant_q;

  logic [GID_W-1:0]   sel_d;
  logic               sel_found;
  logic [GID_W-1:0]   cand;
  logic               g_valid;
  logic               transfer;
  logic               last_beat;

  // Round-robin pick: first valid requester searching upward from last_grant+1
  always_comb begin
    sel_found = 1'b0;
    sel_d     = '0;
    cand      = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      cand = GID_W'((int'(last_grant_q) + k) % N_REQ);
      if (!sel_found && req_valid[cand]) begin
        sel_found = 1'b1;
        sel_d     = cand;
      end
    end
  end

  // Route the granted requester's valid/data and drive its ready
  always_comb begin
    g_valid     = 1'b0;
    fifo_w_data = '0;
    req_ready   = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant_id_q == GID_W'(i)) begin
        g_valid = req_valid[i];
        if (state_q == GRANT) begin
          fifo_w_data  = req_data[i*D_WIDTH +: D_WIDTH];
          req_ready[i] = !fifo_full;
        end
      end
    end
  end

  assign transfer       = (state_q == GRANT) && g_valid && !fifo_full;
  assign last_beat      = (beat_cnt_q == BC_W'(MAX_BURST - 1));
  assign fifo_w_en      = transfer;
  assign grant_valid    = (state_q == GRANT);
  assign grant_id       = grant_id_q;
  assign dbg_state_o    = state_q;
  assign dbg_beat_cnt_o = beat_cnt_q;

  // Grant FSM: arbitrate in IDLE, count beats and release in GRANT
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q      <= IDLE;
      beat_cnt_q   <= '0;
      grant_id_q   <= '0;
      last_grant_q <= GID_W'(N_REQ - 1);
    end else begin
      case (state_q)
        IDLE: begin
          if (sel_found) begin
            grant_id_q <= sel_d;
            beat_cnt_q <= '0;
            state_q    <= GRANT;
          end
        end
        GRANT: begin
          if (transfer) begin
            if (last_beat) begin
              state_q      <= IDLE;
              last_grant_q <= grant_id_q;
              beat_cnt_q   <= '0;
            end else begin
              beat_cnt_q <= beat_cnt_q + BC_W'(1);
            end
          end else if (!g_valid) begin
            // Requester withdrew; stalls on a full FIFO keep the grant instead
            state_q      <= IDLE;
            last_grant_q <= grant_id_q;
            beat_cnt_q   <= '0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: directed scenarios plus randomized traffic,
// all checked every cycle against a queue-based behavioural model.
module tb_fifo_wr_arbiter;

  localparam int N  = 4;
  localparam int W  = 8;
  localparam int MB = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           n_rst;
  logic [N-1:0]   req_valid;
  logic [N*W-1:0] req_data;
  logic [N-1:0]   req_ready;
  logic           fifo_full;
  logic           fifo_w_en;
  logic [W-1:0]   fifo_w_data;
  logic           grant_valid;
  logic [1:0]     grant_id;
  logic           dbg_state;
  logic [2:0]     dbg_beat;

  fifo_wr_arbiter #(.N_REQ(N), .D_WIDTH(W), .MAX_BURST(MB)) dut (
    .clk(clk), .n_rst(n_rst), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .fifo_full(fifo_full), .fifo_w_en(fifo_w_en),
    .fifo_w_data(fifo_w_data), .grant_valid(grant_valid), .grant_id(grant_id),
    .dbg_state_o(dbg_state), .dbg_beat_cnt_o(dbg_beat)
  );

  // Second instance built with single-beat bursts
  logic           n_rst2;
  logic [N-1:0]   v2;
  logic [N*W-1:0] d2;
  logic [N-1:0]   rdy2;
  logic           full2;
  logic           en2;
  logic [W-1:0]   wd2;
  logic           gv2;
  logic [1:0]     gid2;
  logic           st2;
  logic [0:0]     bc2;

  fifo_wr_arbiter #(.N_REQ(N), .D_WIDTH(W), .MAX_BURST(1)) dut_mb1 (
    .clk(clk), .n_rst(n_rst2), .req_valid(v2), .req_data(d2),
    .req_ready(rdy2), .fifo_full(full2), .fifo_w_en(en2),
    .fifo_w_data(wd2), .grant_valid(gv2), .grant_id(gid2),
    .dbg_state_o(st2), .dbg_beat_cnt_o(bc2)
  );

  // ---------------- bookkeeping ----------------
  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Producer queues and monitor logs
  logic [W-1:0] src_q[N][$];
  logic [N-1:0] gate;
  logic [N-1:0] acc_mask;
  logic         rand_mode;
  logic [W-1:0] log_data[$];
  int           log_id[$];
  int           log_cyc[$];
  int           glog[$];
  int           cyc;
  logic         prev_gv;

  // ---------------- behavioural model ----------------
  // Owner of the write port (-1 = nobody), beats moved in this grant,
  // last requester served, and the grant_id the outputs should show.
  int           m_owner;
  int           m_beats;
  int           m_last;
  int           m_gid;
  logic [W-1:0] exp_q[$];

  function automatic void model_reset();
    m_owner = -1;
    m_beats = 0;
    m_last  = N - 1;
    m_gid   = 0;
    exp_q.delete();
  endfunction

  logic         e_gv;
  logic [N-1:0] e_rdy;
  logic         e_en;
  logic [W-1:0] e_data;
  logic         found;
  int           pick;

  // Compare process: check outputs mid-cycle, then advance the model
  initial forever begin
    @(negedge clk);
    cyc++;
    if (!n_rst) begin
      model_reset();
      chk("rst_grant_valid", 32'(grant_valid), 32'd0);
      chk("rst_req_ready", 32'(req_ready), 32'd0);
      chk("rst_w_en", 32'(fifo_w_en), 32'd0);
      chk("rst_w_data", 32'(fifo_w_data), 32'd0);
      prev_gv  = 1'b0;
      acc_mask = '0;
    end else begin
      e_gv  = (m_owner >= 0);
      e_rdy = '0;
      if (e_gv && !fifo_full) e_rdy[m_owner] = 1'b1;
      e_en   = e_gv && req_valid[m_owner] && !fifo_full;
      e_data = e_gv ? req_data[m_owner*W +: W] : '0;
      chk("grant_valid", 32'(grant_valid), 32'(e_gv));
      chk("grant_id", 32'(grant_id), 32'(m_gid));
      chk("req_ready", 32'(req_ready), 32'(e_rdy));
      chk("w_en", 32'(fifo_w_en), 32'(e_en));
      chk("w_data", 32'(fifo_w_data), 32'(e_data));
      chk("state", 32'(dbg_state), 32'(e_gv));
      chk("no_write_when_full", 32'(fifo_w_en & fifo_full), 32'd0);
      if (e_gv) chk("beat_cnt", 32'(dbg_beat), 32'(m_beats));
      // Scoreboard of FIFO writes
      if (e_en) exp_q.push_back(e_data);
      if (fifo_w_en) begin
        if (exp_q.size() == 0) chk("sb_unexpected_write", 32'(fifo_w_data), 32'hFFFF_FFFF);
        else chk("sb_data", 32'(fifo_w_data), 32'(exp_q.pop_front()));
        log_data.push_back(fifo_w_data);
        log_id.push_back(int'(grant_id));
        log_cyc.push_back(cyc);
      end
      if (grant_valid && !prev_gv) glog.push_back(int'(grant_id));
      prev_gv  = grant_valid;
      acc_mask = req_valid & req_ready;
      // Model step for the coming edge
      if (m_owner < 0) begin
        found = 1'b0;
        for (int k = 1; k <= N; k++) begin
          pick = (m_last + k) % N;
          if (!found && req_valid[pick]) begin
            found   = 1'b1;
            m_owner = pick;
            m_gid   = pick;
            m_beats = 0;
          end
        end
      end else if (e_en) begin
        m_beats++;
        if (m_beats == MB) begin
          m_last  = m_owner;
          m_owner = -1;
        end
      end else if (!req_valid[m_owner]) begin
        m_last  = m_owner;
        m_owner = -1;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic apply();
    for (int i = 0; i < N; i++) begin
      req_valid[i]       = (src_q[i].size() > 0) && gate[i];
      req_data[i*W +: W] = (src_q[i].size() > 0) ? src_q[i][0] : '0;
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++)
      if (acc_mask[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
    acc_mask = '0;
    if (rand_mode) begin
      fifo_full = ($urandom_range(0, 3) == 0);
      for (int i = 0; i < N; i++) begin
        if (src_q[i].size() == 0 && $urandom_range(0, 3) == 0)
          for (int j = 0; j < int'($urandom_range(1, MB + 2)); j++)
            src_q[i].push_back(W'($urandom_range(0, 255)));
        gate[i] = ($urandom_range(0, 9) != 0);
      end
    end
    apply();
  endtask

  task automatic clear_logs();
    log_data.delete();
    log_id.delete();
    log_cyc.delete();
    glog.delete();
  endtask

  task automatic do_reset();
    n_rst     = 1'b0;
    fifo_full = 1'b0;
    gate      = '1;
    for (int i = 0; i < N; i++) src_q[i].delete();
    apply();
    step();
    step();
    n_rst = 1'b1;
    clear_logs();
  endtask

  task automatic wait_logs(input int n, input string nm);
    int t;
    t = 0;
    while (log_data.size() < n && t < 200) begin
      step();
      t++;
    end
    chk(nm, 32'(t < 200), 32'd1);
  endtask

  task automatic drain(input string nm);
    int t;
    t = 0;
    while ((src_q[0].size() + src_q[1].size() + src_q[2].size() + src_q[3].size() > 0
            || grant_valid) && t < 400) begin
      step();
      t++;
    end
    chk(nm, 32'(t < 400), 32'd1);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------- stimulus ----------------
  initial begin
    n_rst = 1'b0; fifo_full = 1'b0; req_valid = '0; req_data = '0;
    gate = '1; rand_mode = 1'b0; acc_mask = '0; cyc = 0; prev_gv = 1'b0;
    model_reset();
    n_rst2 = 1'b0; v2 = '0; d2 = '0; full2 = 1'b0;

    // Reset state
    step();
    chk("reset_grant_id", 32'(grant_id), 32'd0);
    chk("reset_beat_cnt", 32'(dbg_beat), 32'd0);
    do_reset();

    // Single requester 2 with three beats, then withdrawn
    src_q[2].push_back(8'h10); src_q[2].push_back(8'h11); src_q[2].push_back(8'h12);
    apply();
    step();
    chk("t1_grant_valid", 32'(grant_valid), 32'd1);
    chk("t1_grant_id", 32'(grant_id), 32'd2);
    wait_logs(3, "t1_wait_beats");
    step(); step();
    chk("t1_released", 32'(grant_valid), 32'd0);
    chk("t1_beats", 32'(log_data.size()), 32'd3);
    for (int k = 0; k < 3; k++) chk("t1_data", 32'(log_data[k]), 32'(8'h10 + k));
    chk("t1_consecutive", 32'(log_cyc[2] - log_cyc[0]), 32'd2);

    // Contention: all four continuously valid
    do_reset();
    for (int i = 0; i < N; i++)
      for (int j = 0; j < 8; j++) src_q[i].push_back(W'(i * 16 + j));
    apply();
    wait_logs(20, "t2_wait_beats");
    for (int k = 0; k < 5; k++) chk("t2_grant_order", 32'(glog[k]), 32'(k % 4));
    for (int k = 0; k < 16; k++) chk("t2_beat_owner", 32'(log_id[k]), 32'(k / 4));
    chk("t2_idle_gap", 32'(log_cyc[4] - log_cyc[3]), 32'd2);
    chk("t2_burst_span", 32'(log_cyc[3] - log_cyc[0]), 32'd3);
    drain("t2_drain");

    // Full stall after the 2nd beat of requester 1
    clear_logs();
    for (int j = 1; j <= 4; j++) src_q[1].push_back(W'(8'h20 + j));
    apply();
    wait_logs(2, "t3_wait_two");
    fifo_full = 1'b1;
    for (int s = 0; s < 3; s++) begin
      if (s > 0) step();
      #1;
      chk("t3_stall_ready", 32'(req_ready), 32'd0);
      chk("t3_stall_wen", 32'(fifo_w_en), 32'd0);
      chk("t3_stall_beat", 32'(dbg_beat), 32'd2);
      chk("t3_stall_hold", 32'(grant_valid), 32'd1);
    end
    step();
    fifo_full = 1'b0;
    wait_logs(4, "t3_wait_four");
    step(); step();
    chk("t3_released", 32'(grant_valid), 32'd0);
    for (int k = 0; k < 4; k++) chk("t3_data", 32'(log_data[k]), 32'(8'h21 + k));

    // Early drop by requester 3 with requester 0 pending
    step(); step();
    clear_logs();
    src_q[3].push_back(8'h3A);
    apply();
    step();
    chk("t4_grant3", 32'(grant_id), 32'd3);
    gate[3] = 1'b0;
    src_q[0].push_back(8'h0A);
    apply();
    step();
    chk("t4_back_idle", 32'(grant_valid), 32'd0);
    step();
    chk("t4_next_grant_valid", 32'(grant_valid), 32'd1);
    chk("t4_next_grant_id", 32'(grant_id), 32'd0);
    chk("t4_no_write", 32'(log_data.size()), 32'd0);
    step(); step();
    chk("t4_req0_write", 32'(log_data.size() > 0 ? log_data[0] : 8'hFF), 32'h0A);
    src_q[3].delete();
    gate[3] = 1'b1;
    apply();
    drain("t4_drain");

    // Reset in the middle of a burst
    clear_logs();
    for (int j = 0; j < 4; j++) src_q[2].push_back(W'(8'h50 + j));
    apply();
    wait_logs(2, "t5_wait_two");
    n_rst = 1'b0;
    #1;
    chk("t5_rst_ready", 32'(req_ready), 32'd0);
    chk("t5_rst_wen", 32'(fifo_w_en), 32'd0);
    chk("t5_rst_gv", 32'(grant_valid), 32'd0);
    for (int i = 0; i < N; i++) src_q[i].delete();
    src_q[0].push_back(8'h60); src_q[2].push_back(8'h62);
    apply();
    step(); step();
    n_rst = 1'b1;
    clear_logs();
    step();
    chk("t5_first_grant_valid", 32'(grant_valid), 32'd1);
    chk("t5_first_grant_id", 32'(grant_id), 32'd0);
    drain("t5_drain");
    chk("t5_first_write", 32'(log_data.size() > 0 ? log_data[0] : 8'hFF), 32'h60);

    // Randomized traffic against the model
    rand_mode = 1'b1;
    for (int c = 0; c < 800; c++) step();
    rand_mode = 1'b0;
    fifo_full = 1'b0;
    gate = '1;
    apply();
    drain("rand_drain");
    step(); step();
    chk("sb_empty", 32'(exp_q.size()), 32'd0);

    // Single-beat build: requesters 0 and 1 always valid
    d2 = {8'h44, 8'h33, 8'h22, 8'h11};
    v2 = 4'b0011;
    @(posedge clk);
    #1;
    n_rst2 = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk("mb1_w_en", 32'(en2), 32'(k % 2));
      chk("mb1_grant_valid", 32'(gv2), 32'(k % 2));
      if (k % 2 == 1) begin
        chk("mb1_grant_id", 32'(gid2), 32'((k / 2) % 2));
        chk("mb1_data", 32'(wd2), ((k / 2) % 2 == 0) ? 32'h11 : 32'h22);
        chk("mb1_ready", 32'(rdy2), 32'(1 << ((k / 2) % 2)));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
